// File: rtl/fpu_pkg.sv
// fpu_pkg: shared binary32 format constants and the unpacked-field view of a
// single-precision word, used by the FPU datapath blocks.
package fpu_pkg;

    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;
    localparam int FP_BIAS = 127;
    localparam logic [FP_EXP_W-1:0] FP_EXP_MAX = 8'hFF;
    localparam logic [31:0] FP_QNAN = 32'hFFC0_0000;

    typedef struct packed {
        logic                sign;
        logic [FP_EXP_W-1:0] exp;
        logic [FP_MAN_W-1:0] man;
    } fp32_t;

endpackage

// File: rtl/fadd_lzc.sv
// fadd_lzc: combinational leading-zero count of the 28-bit adder result
// {carry, hidden, mantissa[22:0], guard, round, sticky}.
// Ports:
//   din   in  28  value to scan
//   count out  5  number of leading zeros (28 when din is zero)
module fadd_lzc (
    input  logic [27:0] din,
    output logic [4:0]  count
);

    // Scan upward so that the highest set bit is the last one to win.
    always_comb begin
        count = 5'd28;
        for (int i = 0; i < 28; i++) begin
            if (din[i]) begin
                count = 5'(27 - i);
            end
        end
    end

endmodule

// File: rtl/fadd_core.sv
// fadd_core: IEEE-754 binary32 adder y = x1 + x2, round-to-nearest-even,
// subnormal-aware, one registered output stage, new operands every cycle.
// Ports:
//   clk  in   1  clock, rising edge
//   rst  in   1  synchronous active-high reset (y=0, ovf=0)
//   x1   in  32  operand 1 {sign, exp[7:0], man[22:0]}
//   x2   in  32  operand 2
//   y    out 32  registered sum
//   ovf  out  1  registered flag: finite operands produced an infinity
module fadd_core
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic [31:0] y,
    output logic        ovf
);

    fp32_t op1, op2, big, sml;
    logic op1_nan, op2_nan, op1_inf, op2_inf, op1_zero, op2_zero;
    logic swap, eff_sub;
    logic [7:0]  big_e, sml_e, exp_diff;
    logic [23:0] big_m, sml_m;
    logic [4:0]  shamt, lz, lshift;
    logic [49:0] sml_shift;
    logic [26:0] big_al, sml_al, norm;
    logic [27:0] mag_sum;
    logic [9:0]  norm_exp, exp_fin;
    logic        round_up;
    logic [24:0] mant_rnd;
    logic [23:0] mant_fin;
    logic [31:0] gen_res, y_next, y_reg;
    logic        ovf_next, ovf_reg;

    assign op1 = x1;
    assign op2 = x2;

    assign op1_nan  = (op1.exp == FP_EXP_MAX) && (op1.man != '0);
    assign op2_nan  = (op2.exp == FP_EXP_MAX) && (op2.man != '0);
    assign op1_inf  = (op1.exp == FP_EXP_MAX) && (op1.man == '0);
    assign op2_inf  = (op2.exp == FP_EXP_MAX) && (op2.man == '0);
    assign op1_zero = (op1.exp == '0) && (op1.man == '0);
    assign op2_zero = (op2.exp == '0) && (op2.man == '0);

    // Order by magnitude so the subtraction below never goes negative.
    assign swap = {op2.exp, op2.man} > {op1.exp, op1.man};
    assign big  = swap ? op2 : op1;
    assign sml  = swap ? op1 : op2;

    // Subnormals use effective exponent 1 with a clear hidden bit.
    assign big_e = (big.exp == '0) ? 8'd1 : big.exp;
    assign sml_e = (sml.exp == '0) ? 8'd1 : sml.exp;
    assign big_m = {big.exp != '0, big.man};
    assign sml_m = {sml.exp != '0, sml.man};

    // Beyond 26 positions every bit of the smaller operand lands in sticky.
    assign exp_diff  = big_e - sml_e;
    assign shamt     = (exp_diff > 8'd26) ? 5'd26 : exp_diff[4:0];
    assign sml_shift = {sml_m, 26'd0} >> shamt;
    assign sml_al    = {sml_shift[49:24], |sml_shift[23:0]};
    assign big_al    = {big_m, 3'b000};

    assign eff_sub = big.sign ^ sml.sign;
    assign mag_sum = eff_sub ? ({1'b0, big_al} - {1'b0, sml_al})
                             : ({1'b0, big_al} + {1'b0, sml_al});

    fadd_lzc u_lzc (
        .din   (mag_sum),
        .count (lz)
    );

    // Normalise: carry -> one right shift; otherwise left shift to bring the
    // MSB to bit 26, capped so the exponent stops at 1 (subnormal result).
    always_comb begin
        lshift   = 5'd0;
        norm     = '0;
        norm_exp = '0;
        if (mag_sum[27]) begin
            norm     = {mag_sum[27:2], mag_sum[1] | mag_sum[0]};
            norm_exp = {2'b00, big_e} + 10'd1;
        end else begin
            lshift = lz - 5'd1;
            if ({3'b000, lshift} > (big_e - 8'd1)) begin
                lshift = 5'(big_e - 8'd1);
            end
            norm     = mag_sum[26:0] << lshift;
            norm_exp = {2'b00, big_e} - {5'b00000, lshift};
        end
    end

    // Round to nearest even on guard (norm[2]), round (norm[1]), sticky (norm[0]).
    assign round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    assign mant_rnd = {1'b0, norm[26:3]} + {24'd0, round_up};

    always_comb begin
        if (mant_rnd[24]) begin
            mant_fin = mant_rnd[24:1];
            exp_fin  = norm_exp + 10'd1;
        end else begin
            mant_fin = mant_rnd[23:0];
            exp_fin  = norm_exp;
        end
    end

    // A clear hidden bit after rounding means the result stayed subnormal.
    always_comb begin
        if (exp_fin >= 10'd255) begin
            gen_res = {big.sign, FP_EXP_MAX, 23'd0};
        end else if (mag_sum == '0) begin
            gen_res = 32'h0000_0000;
        end else begin
            gen_res = {big.sign, mant_fin[23] ? exp_fin[7:0] : 8'd0, mant_fin[22:0]};
        end
    end

    always_comb begin
        y_next = gen_res;
        if (op1_nan) begin
            y_next = {op1.sign, op1.exp, 1'b1, op1.man[21:0]};
        end else if (op2_nan) begin
            y_next = {op2.sign, op2.exp, 1'b1, op2.man[21:0]};
        end else if (op1_inf && op2_inf && (op1.sign != op2.sign)) begin
            y_next = FP_QNAN;
        end else if (op1_inf) begin
            y_next = x1;
        end else if (op2_inf) begin
            y_next = x2;
        end else if (op1_zero && op2_zero) begin
            y_next = {op1.sign & op2.sign, 31'd0};
        end else if (op2_zero) begin
            y_next = x1;
        end else if (op1_zero) begin
            y_next = x2;
        end
        ovf_next = (op1.exp != FP_EXP_MAX) && (op2.exp != FP_EXP_MAX)
                   && (y_next[30:23] == FP_EXP_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_reg   <= 32'h0;
            ovf_reg <= 1'b0;
        end else begin
            y_reg   <= y_next;
            ovf_reg <= ovf_next;
        end
    end

    assign y   = y_reg;
    assign ovf = ovf_reg;

endmodule

// File: tb/tb_fadd_core.sv
// tb_fadd_core: scoreboard bench for fadd_core. Expected sums come from an
// exact wide-integer reference (operands scaled to units of 2^-149, summed
// exactly, then rounded once) or from a directed table of known answers.
module tb_fadd_core;
    import fpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] x1 = 32'h0;
    logic [31:0] x2 = 32'h0;
    logic [31:0] y;
    logic        ovf;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
        logic        ovf;
    } txn_t;

    txn_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   txn_count = 0;
    logic in_valid = 1'b0;
    logic out_pending = 1'b0;

    localparam logic [31:0] ONE_F = {1'b0, 8'(FP_BIAS), 23'd0};

    fadd_core dut (
        .clk (clk),
        .rst (rst),
        .x1  (x1),
        .x2  (x2),
        .y   (y),
        .ovf (ovf)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, want);
        end
    endtask

    function automatic logic [32:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        logic        sa, sb, sign, up, rovf;
        logic [7:0]  ea, eb;
        logic [22:0] ma, mb;
        logic [299:0] va, vb, mag, keep, rem, half, one;
        logic [31:0] res;
        int p, s, e, sh_a, sh_b;
        sa = a[31]; sb = b[31];
        ea = a[30:23]; eb = b[30:23];
        ma = a[22:0]; mb = b[22:0];
        one = 300'd1;
        if (ea == 8'hFF && ma != 0) begin
            res = a | 32'h0040_0000;
        end else if (eb == 8'hFF && mb != 0) begin
            res = b | 32'h0040_0000;
        end else if (ea == 8'hFF && eb == 8'hFF) begin
            res = (sa != sb) ? 32'hFFC0_0000 : a;
        end else if (ea == 8'hFF) begin
            res = a;
        end else if (eb == 8'hFF) begin
            res = b;
        end else begin
            sh_a = (ea == 0) ? 0 : int'(ea) - 1;
            sh_b = (eb == 0) ? 0 : int'(eb) - 1;
            va = 300'({ea != 0, ma}) << sh_a;
            vb = 300'({eb != 0, mb}) << sh_b;
            if (sa == sb) begin
                mag = va + vb; sign = sa;
            end else if (va >= vb) begin
                mag = va - vb; sign = sa;
            end else begin
                mag = vb - va; sign = sb;
            end
            if (mag == 0) sign = sa & sb;
            p = -1;
            for (int i = 299; i >= 0; i--) begin
                if (p < 0 && mag[i]) p = i;
            end
            if (p <= 23) begin
                res = {sign, mag[30:0]};
            end else begin
                s = p - 23;
                keep = mag >> s;
                rem = mag & ((one << s) - one);
                half = one << (s - 1);
                up = (rem > half) || (rem == half && keep[0]);
                keep = keep + 300'(up);
                if (keep[24]) begin
                    keep = keep >> 1;
                    s++;
                end
                e = s + 1;
                if (e >= 255) res = {sign, 8'hFF, 23'd0};
                else res = {sign, 8'(e), keep[22:0]};
            end
        end
        rovf = (ea != 8'hFF) && (eb != 8'hFF) && (res[30:23] == 8'hFF);
        return {res, rovf};
    endfunction

    // Present one operand pair for one cycle and queue its expected result.
    task automatic drive(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] want_y, input logic want_ovf);
        txn_t t;
        t.a = a; t.b = b; t.y = want_y; t.ovf = want_ovf;
        sb_q.push_back(t);
        x1 = a; x2 = b; in_valid = 1'b1;
        @(negedge clk);
    endtask

    task automatic drive_ref(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] r;
        r = ref_add(a, b);
        drive(a, b, r[32:1], r[0]);
    endtask

    function automatic logic [31:0] rand_operand();
        logic [7:0]  e;
        logic [22:0] m;
        int sel;
        sel = $urandom_range(0, 7);
        case (sel)
            0: e = 8'd0;
            1: e = 8'd1;
            2: e = 8'd254;
            3: e = 8'd255;
            default: e = 8'($urandom_range(0, 255));
        endcase
        case ($urandom_range(0, 7))
            0: m = 23'd0;
            1: m = 23'd1;
            2: m = 23'd2;
            3: m = 23'h380000;
            4: m = 23'h400000;
            5: m = 23'h5FFFFF;
            6: m = 23'h7FFFFF;
            default: m = 23'($urandom());
        endcase
        return {1'($urandom_range(0, 1)), e, m};
    endfunction

    // Scoreboard: a result is due at the negedge after each non-reset edge
    // that captured a valid operand pair.
    always @(posedge clk) out_pending <= in_valid && !rst;

    always @(negedge clk) begin : monitor
        txn_t t;
        if (out_pending) begin
            check_val("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                t = sb_q.pop_front();
                check_val("y", y, t.y);
                check_val("ovf", {31'd0, ovf}, {31'd0, t.ovf});
                txn_count++;
                $display("txn %0d: %08h + %08h -> y=%08h ovf=%0b (want %08h/%0b)",
                         txn_count, t.a, t.b, y, ovf, t.y, t.ovf);
            end
        end
    end

    initial begin
        logic [31:0] dir_a[19], dir_b[19], dir_y[19];
        logic        dir_o[19];
        logic [22:0] m1, m2, mask;
        logic [7:0]  ce;
        logic        cs;
        int k;

        dir_a = '{ONE_F,        32'h3F80_0000, 32'h7F7F_FFFF, 32'h7F80_0000, 32'h7F80_0000,
                  32'h7F80_0001, 32'h0000_0001, 32'h007F_FFFF, 32'h8000_0000, 32'h8000_0000,
                  32'h3F80_0000, 32'h3F80_0001, 32'h8000_0001, 32'hFF80_0001, 32'h3F80_0000,
                  32'h3F80_0001, 32'h0080_0000, 32'hFF7F_FFFF, 32'h0000_0000};
        dir_b = '{32'h3F80_0000, 32'hBF80_0000, 32'h7F7F_FFFF, 32'h3F80_0000, 32'hFF80_0000,
                  32'h3F80_0000, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 32'h8000_0000,
                  32'h3380_0000, 32'h3380_0000, 32'h0000_0000, 32'h7FC0_0000, 32'h7F80_0001,
                  32'hBF80_0000, 32'h8000_0001, 32'hFF7F_FFFF, 32'h8000_0000};
        dir_y = '{32'h4000_0000, 32'h0000_0000, 32'h7F80_0000, 32'h7F80_0000, 32'hFFC0_0000,
                  32'h7FC0_0001, 32'h0000_0002, 32'h0080_0000, 32'h0000_0000, 32'h8000_0000,
                  32'h3F80_0000, 32'h3F80_0002, 32'h8000_0001, 32'hFFC0_0001, 32'h7FC0_0001,
                  32'h3400_0000, 32'h007F_FFFF, 32'hFF80_0000, 32'h0000_0000};
        dir_o = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                  1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                  1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                  1'b0, 1'b0, 1'b1, 1'b0};

        // Reset for two edges with live operands; they must be discarded.
        rst = 1'b1;
        x1 = 32'h3F80_0000;
        x2 = 32'h3F80_0000;
        @(posedge clk);
        @(negedge clk);
        check_val("rst_y_1", y, 32'h0);
        check_val("rst_ovf_1", {31'd0, ovf}, 32'd0);
        @(negedge clk);
        check_val("rst_y_2", y, 32'h0);
        check_val("rst_ovf_2", {31'd0, ovf}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            drive(dir_a[i], dir_b[i], dir_y[i], dir_o[i]);
        end

        // Broad sweep over exponent/mantissa corners and random values.
        for (int i = 0; i < 6000; i++) begin
            drive_ref(rand_operand(), rand_operand());
        end

        // Massive cancellation: equal exponents, shared upper mantissa bits.
        for (int i = 0; i < 1500; i++) begin
            ce = 8'($urandom_range(0, 254));
            cs = 1'($urandom_range(0, 1));
            m1 = 23'($urandom());
            k = $urandom_range(0, 23);
            mask = 23'((32'd1 << k) - 32'd1);
            m2 = (m1 & ~mask) | (23'($urandom()) & mask);
            drive_ref({cs, ce, m1}, {~cs, ce, m2});
        end

        in_valid = 1'b0;
        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
        check_val("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
